// File: rtl/prog_loader.sv
// prog_loader: assembles a little-endian byte stream into 16-bit words, writes them to
// sequential program-RAM addresses and holds the CPU in reset until a full image is loaded.
// Stream format: N (word count), then N x {lo, hi}.
// Optional: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLen   = 3'd1,
    StLo    = 3'd2,
    StHi    = 3'd3,
    StWrite = 3'd4,
    StFin   = 3'd5
`ifdef PROG_LOADER_CHECKSUM_EN
    , StChk = 3'd6
`endif
  } state_e;

  state_e                state_q, state_d;
  state_e                end_state;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            lo_q, lo_d;
  logic [7:0]            hi_q, hi_d;
  logic                  done_q, done_d;
  logic                  accept;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            acc_q, acc_d;
  logic                  err_q, err_d;
  // The image is only trusted after the checksum byte has been compared.
  assign end_state = StChk;
  assign err       = err_q;
`else
  assign end_state = StFin;
  assign err       = 1'b0;
`endif

  assign accept  = in_valid & in_ready;
  assign wr_addr = addr_q;
  assign wr_data = {hi_q, lo_q};
  assign done    = done_q;
  // done_q is only ever set on a successful entry to FIN, so this releases the CPU only there.
  assign cpu_rst = ~done_q;

  // State-decoded handshake, write strobe and busy flag.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      StIdle, StFin:     busy     = 1'b0;
      StLen, StLo, StHi: in_ready = 1'b1;
      StWrite:           wr_en    = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      StChk:             in_ready = 1'b1;
`endif
      default:           busy     = 1'b1;
    endcase
  end

  // Next-state logic: stream parsing, address/count bookkeeping and completion flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    done_d  = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
    err_d   = err_q;
    if (accept) acc_d = acc_q ^ in_data;
`endif
    unique case (state_q)
      StIdle, StFin: begin
        if (start) begin
          state_d = StLen;
          addr_d  = '0;
          done_d  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          acc_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      StLen: begin
        if (accept) begin
          cnt_d = in_data;
          if (in_data == 8'd0) begin
            state_d = end_state;
            done_d  = (end_state == StFin);
          end else begin
            state_d = StLo;
          end
        end
      end
      StLo: begin
        if (accept) begin
          lo_d    = in_data;
          state_d = StHi;
        end
      end
      StHi: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        // Address wraps modulo DEPTH; oversize images silently overwrite earlier words.
        addr_d = addr_q + ADDR_WIDTH'(1);
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = end_state;
          done_d  = (end_state == StFin);
        end else begin
          state_d = StLo;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) begin
          state_d = StFin;
          if (in_data == acc_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
